// File: rtl/mips_mem_bus_responder.sv
// mips_mem_bus_responder
// Word-organised memory slave for a MIPS-style CPU bus with a fixed
// number of stall cycles per transaction and a sticky error flag.
//
// Ports:
//   clk         single clock; all state changes on its rising edge
//   reset       synchronous, active-high; aborts any transaction, keeps memory
//   address     byte address from the initiator
//   read/write  request strobes, held by the initiator until completion
//   writedata   write data
//   byteenable  per-byte write enable; bit n selects bits [8n+7:8n]
//   waitrequest high while the current request is not yet complete
//   readdata    read result, valid in the completion cycle, held afterwards
//   err         sticky error flag (misaligned, out of range, read+write)
//   fsm_state   debug view of the FSM: 0=IDLE, 1=WAIT, 2=DONE
//
// Handshake: the initiator raises read or write and holds it (with the
// request fields) while waitrequest is high. The request is latched in the
// first IDLE cycle it is seen; the cycle with waitrequest low is the
// completion cycle. Dropping both strobes before completion aborts the
// transaction. A request seen during the completion cycle is only accepted
// in the following IDLE cycle.
module mips_mem_bus_responder #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err,
  output logic [1:0]  fsm_state
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept;

  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        lat_read;
  logic        lat_write;

  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] done_rdata;

  logic [31:0] index;
  logic [IDX_W-1:0] widx;
  logic        bad;

  logic [31:0] mem [MEM_WORDS];

  // 32-bit unsigned subtraction: addresses below BASE_ADDR wrap to a huge
  // index and therefore land out of range.
  assign index = (lat_addr - BASE_ADDR) >> 2;
  assign widx  = index[IDX_W-1:0];
  assign bad   = (lat_addr[1:0] != 2'b00) ||
                 (index >= 32'(MEM_WORDS)) ||
                 (lat_read && lat_write);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    waitrequest = 1'b0;
    accept      = 1'b0;
    done_rdata  = rdata_q;
    case (state)
      IDLE: begin
        if (read || write) begin
          waitrequest = 1'b1;
          accept      = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = DONE;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        waitrequest = 1'b1;
        if (!read && !write) begin
          // Initiator withdrew the request: abort without side effects.
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        if (bad) begin
          done_rdata = 32'h0;
        end else if (lat_read) begin
          done_rdata = mem[widx];
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outside the completion cycle done_rdata is the held value.
  assign readdata  = done_rdata;
  assign err       = err_q;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_addr  <= address;
        lat_wdata <= writedata;
        lat_be    <= byteenable;
        lat_read  <= read;
        lat_write <= write;
      end
      if (state == DONE) begin
        rdata_q <= done_rdata;
        if (bad) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Memory is never cleared; a write lands only at the end of a clean
  // completion cycle that is not overridden by reset.
  always_ff @(posedge clk) begin
    if (!reset && state == DONE && lat_write && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) begin
          mem[widx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
